aes_iter_core: RTL and testbench
================================

AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 SHALL have parameter NK, default 4, meaning key length in 32-bit words; legal values 4/6/8 (AES-128/192/256); any other value is an elaboration error.
REQ-002 SHALL have derived localparam NR = NK+6, the number of rounds.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  core can accept a request this cycle.
REQ-007 mode  input  1  0 = encrypt, 1 = decrypt; sampled with the request.
REQ-008 key  input  NK*32  cipher key, MSB-first FIPS-197 byte order; sampled with the request.
REQ-009 data_in  input  128  plaintext (enc) or ciphertext (dec) block.
REQ-010 out_valid  output  1  data_out holds a finished result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 data_out  output  128  result block.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, ROUND, FINAL, DONE.
REQ-015 Request SHALL be accepted on an edge where in_valid && in_ready; key, mode and data_in are latched, and the FSM goes IDLE/DONE -> LOAD.
REQ-016 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready), giving back-to-back accept on the result-consume edge.
REQ-017 LOAD: state register <= latched data XOR round key 0 (enc) or round key NR (dec); round counter <= 1; -> ROUND.
REQ-018 ROUND, enc: one full round per cycle (SubBytes, ShiftRows, MixColumns, AddRoundKey with key[counter]).
REQ-019 ROUND, dec: one full inverse round per cycle (InvShiftRows, InvSubBytes, AddRoundKey with key[NR-counter], InvMixColumns).
REQ-020 ROUND SHALL repeat until counter == NR-1, incrementing the counter each cycle, then -> FINAL.
REQ-021 FINAL: last round without (Inv)MixColumns using key NR (enc) or key 0 (dec); data_out <= result; out_valid <= 1; -> DONE.
REQ-022 Latency SHALL be exactly NR+1 rising edges from the accept edge to out_valid high (11/13/15 for NK=4/6/8).
REQ-023 DONE: data_out and out_valid SHALL hold stable while out_ready is low.
REQ-024 DONE with out_ready high: out_valid <= 0 -> IDLE, or -> LOAD if in_valid is also high.
REQ-025 Changes on key, mode or data_in after acceptance SHALL NOT affect the result in flight.
REQ-026 Key schedule SHALL be expanded from the latched key only; all 4*NR+4 words are available from LOAD onward.
REQ-027 in_valid while busy and not consumable SHALL be ignored (no queueing); the requester holds in_valid.

Reset
REQ-028 reset SHALL force state IDLE, out_valid 0, data_out 0, round counter 0, state register 0, latched key/mode 0; busy 0 and in_ready 1 on the following cycle.
REQ-029 reset SHALL take priority over every handshake and abort any operation in flight with no result produced.

Structure
REQ-030 aes_pkg SHALL hold the FSM state enum, function nr(nk), constant sbox and inverse sbox tables, and GF(2^8) xtime/multiply functions.
REQ-031 A single sub-module aes_round_unit SHALL be instantiated once; it is combinational, with inputs state, round_key, inv, last and output next_state, and implements both forward and inverse rounds.
REQ-032 Key expansion SHALL be combinational from the latched key register; no per-round key storage beyond it.

Verification
REQ-033 NK=4, mode 0, key 000102..0f, data 00112233445566778899aabbccddeeff -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid on the 11th edge after accept.
REQ-034 NK=4, mode 1, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a -> data_out 00112233445566778899aabbccddeeff.
REQ-035 NK=6, key 000102..17 -> dda97ca4864cdfe06eaf70a0ec0d7191 at 13 edges; NK=8, key 000102..1f -> 8ea2b7ca516745bfeafc49904b496089 at 15 edges.
REQ-036 out_ready low for 5 cycles in DONE, with key/data toggled during ROUND -> data_out stable and correct, in_ready low; raise out_ready with in_valid high -> next block accepted on that same edge.
REQ-037 Assert reset at ROUND counter 5 -> next cycle out_valid 0, busy 0, in_ready 1, data_out 0; a new request then completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, S-box tables and GF(2^8) helpers
// used by the iterative core and its round unit.
package aes_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } aes_state_t;

  // Row r of each table holds entries 16r..16r+15; entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_T = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX_T = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic int nr(input int nk);
    return nk + 6;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return SBOX_T[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = {b, 3'b000};
    return INV_SBOX_T[11'd2047 - idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    case (j)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ gf_mul(a1, 8'h03) ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ gf_mul(a2, 8'h03) ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ gf_mul(a3, 8'h03),
            gf_mul(a0, 8'h03) ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_round_unit.sv
// Combinational AES round: forward (SubBytes/ShiftRows/MixColumns/AddRoundKey) or
// inverse (InvShiftRows/InvSubBytes/AddRoundKey/InvMixColumns); last drops the mix step.
module aes_round_unit
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         inv,
  input  logic         last,
  output logic [127:0] next_state
);

  logic [127:0] w_fwd_sr;
  logic [127:0] w_fwd_mc;
  logic [127:0] w_inv_sb;
  logic [127:0] w_inv_ark;
  logic [127:0] w_inv_mc;

  // Byte k lives at [127-8k -: 8]; column c is bytes 4c..4c+3 and row r = k % 4.
  always_comb begin
    w_fwd_sr = '0;
    w_inv_sb = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_fwd_sr[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
        w_inv_sb[127-8*(4*c+r) -: 8] = inv_sbox(state[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
  end

  assign w_inv_ark = w_inv_sb ^ round_key;

  always_comb begin
    w_fwd_mc = '0;
    w_inv_mc = '0;
    for (int c = 0; c < 4; c++) begin
      w_fwd_mc[127-32*c -: 32] = mix_col(w_fwd_sr[127-32*c -: 32]);
      w_inv_mc[127-32*c -: 32] = inv_mix_col(w_inv_ark[127-32*c -: 32]);
    end
  end

  assign next_state = inv ? (last ? w_inv_ark : w_inv_mc)
                          : ((last ? w_fwd_sr : w_fwd_mc) ^ round_key);

endmodule

// File: rtl/aes_iter_core.sv
// Iterative AES-128/192/256 encrypt/decrypt core, one round per clock, with a
// combinational key schedule expanded from the latched key.
module aes_iter_core
  import aes_pkg::*;
#(
  parameter int NK = 4
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [NK*32-1:0] key,
  input  logic [127:0]     data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     data_out,
  output logic             busy,
  output logic [2:0]       o_dbg_state
);

  localparam int NR = nr(NK);
  localparam int NW = 4 * (NR + 1);

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("aes_iter_core: NK must be 4, 6 or 8");
  end

  // Handshakes: a request transfers on a rising edge with in_valid && in_ready; a
  // result transfers on a rising edge with out_valid && out_ready. Requests are not queued.
  aes_state_t       r_state;
  aes_state_t       w_state_nxt;
  logic [3:0]       r_cnt;
  logic [127:0]     r_blk;
  logic [127:0]     r_dout;
  logic [NK*32-1:0] r_key;
  logic             r_mode;
  logic             r_out_valid;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_last;
  logic [3:0]       w_rk_idx;
  logic [127:0]     w_rk;
  logic [127:0]     w_round_out;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    w_accept    = in_valid && w_in_ready;
    w_last      = (r_state == S_FINAL);
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_LOAD;
      S_LOAD:  w_state_nxt = S_ROUND;
      S_ROUND: if (r_cnt == 4'(NR - 1)) w_state_nxt = S_FINAL;
      S_FINAL: w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = w_accept ? S_LOAD : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Decryption walks the schedule backwards: NR at LOAD, NR-counter in ROUND, 0 at FINAL.
  always_comb begin
    w_rk_idx = 4'd0;
    case (r_state)
      S_LOAD:  w_rk_idx = r_mode ? 4'(NR) : 4'd0;
      S_ROUND: w_rk_idx = r_mode ? (4'(NR) - r_cnt) : r_cnt;
      S_FINAL: w_rk_idx = r_mode ? 4'd0 : 4'(NR);
      default: w_rk_idx = 4'd0;
    endcase
  end

  always_comb begin : p_key_sched
    logic [31:0] ks [NW];
    logic [31:0] t;
    t = '0;
    for (int i = 0; i < NW; i++) ks[i] = '0;
    for (int i = 0; i < NK; i++) ks[i] = r_key[NK*32-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = ks[i-1];
      if (i % NK == 0)
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon(4'(i / NK)), 24'h000000};
      else if (NK > 6 && i % NK == 4)
        t = sub_word(t);
      ks[i] = ks[i-NK] ^ t;
    end
    w_rk = '0;
    for (int k = 0; k <= NR; k++) begin
      if (w_rk_idx == 4'(k)) w_rk = {ks[4*k], ks[4*k+1], ks[4*k+2], ks[4*k+3]};
    end
  end

  aes_round_unit u_round (
    .state      (r_blk),
    .round_key  (w_rk),
    .inv        (r_mode),
    .last       (w_last),
    .next_state (w_round_out)
  );

  // The request block is latched straight into r_blk; LOAD then whitens it in place.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key       <= '0;
      r_mode      <= 1'b0;
      r_blk       <= '0;
      r_cnt       <= 4'd0;
      r_dout      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_key  <= key;
        r_mode <= mode;
        r_blk  <= data_in;
      end
      case (r_state)
        S_LOAD: begin
          r_blk <= r_blk ^ w_rk;
          r_cnt <= 4'd1;
        end
        S_ROUND: begin
          r_blk <= w_round_out;
          r_cnt <= r_cnt + 4'd1;
        end
        S_FINAL: begin
          r_dout      <= w_round_out;
          r_out_valid <= 1'b1;
        end
        S_DONE: if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign data_out    = r_dout;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_iter_core.sv
// Bench for aes_iter_core: FIPS-197 vectors on NK=4/6/8 instances, output stall,
// back-to-back accept and mid-operation reset, checked through a tagged result queue.
module tb_aes_iter_core;

  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ROUND = 3'd2;

  logic         clk;
  logic         reset;
  logic         mode;
  logic [255:0] key_w;
  logic [127:0] din;
  logic [2:0]   iv;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [2:0]   ordy;
  logic [2:0]   bz;
  logic [127:0] dout [3];
  logic [2:0]   dbg  [3];

  logic [129:0] exp_q [$];
  logic [129:0] mon_item;
  int n_checks = 0;
  int n_errors = 0;

  // Instance g runs with NK = 4 + 2g and takes the top NK words of the shared key bus.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int GNK = 4 + 2 * g;
    aes_iter_core #(.NK(GNK)) u_dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (iv[g]),
      .in_ready    (ir[g]),
      .mode        (mode),
      .key         (key_w[255 -: GNK*32]),
      .data_in     (din),
      .out_valid   (ov[g]),
      .out_ready   (ordy[g]),
      .data_out    (dout[g]),
      .busy        (bz[g]),
      .o_dbg_state (dbg[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, got timeout required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Call just after a rising edge; returns #1 after the accept edge.
  task automatic issue(input int k, input logic m, input logic [127:0] d,
                       input logic [127:0] e, input bit push);
    bit got;
    got   = 1'b0;
    mode  = m;
    din   = d;
    iv[k] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ir[k]) begin
        got = 1'b1;
        break;
      end
    end
    chk_bit("accept_seen", got, 1'b1);
    if (got) begin
      @(posedge clk);
      if (push) exp_q.push_back({2'(k), e});
      #1;
    end
    iv[k] = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(input int k, input int exp_lat, input bit scramble);
    int seen;
    seen = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (scramble && n >= 2 && n <= 6) begin
        key_w = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
        din   = {$urandom(), $urandom(), $urandom(), $urandom()};
        mode  = 1'($urandom_range(0, 1));
      end
      if (ov[k]) begin
        seen = n;
        break;
      end
    end
    chk_int("latency", seen, exp_lat);
  endtask

  // Scoreboard monitor: every transferred result is matched against the queue head.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && ordy[k]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_output: inst %0d got %h required no result", k, dout[k]);
        end else begin
          mon_item = exp_q.pop_front();
          chk_int("result_inst", k, int'(mon_item[129:128]));
          chk("result_data", dout[k], mon_item[127:0]);
        end
      end
    end
  end

  initial begin
    bit saw;
    reset = 1'b1;
    mode  = 1'b0;
    key_w = KEY256;
    din   = '0;
    iv    = '0;
    ordy  = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_out_valid", ov[0], 1'b0);
    chk_bit("rst_busy", bz[0], 1'b0);
    chk_bit("rst_in_ready", ir[0], 1'b1);
    chk("rst_data_out", dout[0], '0);
    chk_int("rst_state", int'(dbg[0]), int'(ST_IDLE));
    @(posedge clk);
    #1 reset = 1'b0;

    // FIPS-197 vectors on each key size
    issue(0, 1'b0, PT, CT4, 1'b1);
    wait_result(0, 11, 1'b0);
    issue(0, 1'b1, CT4, PT, 1'b1);
    wait_result(0, 11, 1'b0);
    issue(1, 1'b0, PT, CT6, 1'b1);
    wait_result(1, 13, 1'b0);
    issue(2, 1'b0, PT, CT8, 1'b1);
    wait_result(2, 15, 1'b0);
    issue(2, 1'b1, CT8, PT, 1'b1);
    wait_result(2, 15, 1'b0);

    // Inputs scrambled in flight, then a 5-cycle output stall with a pending request
    ordy[0] = 1'b0;
    issue(0, 1'b0, PT, CT4, 1'b1);
    wait_result(0, 11, 1'b1);
    key_w = KEY256;
    din   = CT4;
    mode  = 1'b1;
    iv[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", dout[0], CT4);
      chk_bit("stall_valid", ov[0], 1'b1);
      chk_bit("stall_in_ready", ir[0], 1'b0);
      @(posedge clk);
      #1;
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    exp_q.push_back({2'd0, PT});
    #1 iv[0] = 1'b0;
    chk_int("b2b_state", int'(dbg[0]), int'(ST_LOAD));
    chk_bit("b2b_out_valid", ov[0], 1'b0);
    chk_bit("b2b_busy", bz[0], 1'b1);
    wait_result(0, 11, 1'b0);

    // Reset in the middle of ROUND (counter 5) aborts without a result
    issue(0, 1'b0, PT, CT4, 1'b0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk_int("abort_pre_state", int'(dbg[0]), int'(ST_ROUND));
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_bit("abort_out_valid", ov[0], 1'b0);
    chk_bit("abort_busy", bz[0], 1'b0);
    chk_bit("abort_in_ready", ir[0], 1'b1);
    chk("abort_data_out", dout[0], '0);
    reset = 1'b0;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0]) saw = 1'b1;
    end
    chk_bit("abort_no_result", saw, 1'b0);
    @(posedge clk);
    #1;
    issue(0, 1'b1, CT4, PT, 1'b1);
    wait_result(0, 11, 1'b0);

    repeat (3) @(posedge clk);
    chk_int("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
